// File: rtl/minifloat_pkg.sv
// minifloat_pkg: shared types and widths for consumers of the int2float
// minifloat stream (4-bit mantissa, 3-bit exponent, 11-bit integer range).
package minifloat_pkg;

   localparam int MANT_W = 4;
   localparam int EXP_W  = 3;
   localparam int INT_W  = 11;

   // Accumulator frame state: collecting words, or holding a finished total.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // One minifloat word as produced by int2float.
   typedef struct packed {
      logic [MANT_W-1:0] m;
      logic [EXP_W-1:0]  e;
   } mf_word_t;

endpackage : minifloat_pkg

// File: rtl/minifloat_decode.sv
// minifloat_decode: combinational expansion of a minifloat word back to its
// integer value, value = m << e. Words that are not normalised are expanded
// by the same rule without complaint.
module minifloat_decode
   import minifloat_pkg::*;
(
   input  mf_word_t           i_word,
   output logic [INT_W-1:0]   o_value
);

   assign o_value = INT_W'(i_word.m) << i_word.e;

endmodule : minifloat_decode

// File: rtl/minifloat_accum.sv
// minifloat_accum: sums decoded minifloat words over a frame and presents
// one total per frame on a valid/ready output.
// A frame closes on in_last or when FRAME_MAX words have been taken.
// Build option MINIFLOAT_ACCUM_SAT_EN: when defined the accumulator clamps
// at all-ones on overflow for the rest of the frame; otherwise it wraps.
// out_ovf flags the overflow in both builds.
module minifloat_accum
   import minifloat_pkg::*;
#(
   parameter int ACC_W     = 16,
   parameter int CNT_W     = 6,
   parameter int FRAME_MAX = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_m,
   input  logic [2:0]       in_e,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] FRAME_MAX_C = CNT_W'(FRAME_MAX);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               r_ovf;
   logic               w_ovf_nxt;
   logic               w_accept;
   mf_word_t           w_word;
   logic [INT_W-1:0]   w_value;
   logic [ACC_W:0]     w_sum;

   assign w_word.m = in_m;
   assign w_word.e = in_e;

   minifloat_decode u_decode (
      .i_word  (w_word),
      .o_value (w_value)
   );

   // Handshake flags come straight from the state register.
   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == HOLD);
   assign w_accept  = in_valid && in_ready;

   // One extra bit on the sum captures the carry out of the accumulator.
   assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - INT_W){1'b0}}, w_value};
   assign w_cnt_inc = r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

   // Next-state, accumulator, counter and overflow update.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_ovf;
      case (r_state)
         ACCUM: begin
            if (w_accept) begin
`ifdef MINIFLOAT_ACCUM_SAT_EN
               if (w_sum[ACC_W] || r_ovf) begin
                  w_acc_nxt = {ACC_W{1'b1}};
               end else begin
                  w_acc_nxt = w_sum[ACC_W-1:0];
               end
`else
               w_acc_nxt = w_sum[ACC_W-1:0];
`endif
               w_cnt_nxt = w_cnt_inc;
               w_ovf_nxt = r_ovf | w_sum[ACC_W];
               if (in_last || (w_cnt_inc == FRAME_MAX_C)) begin
                  w_state_nxt = HOLD;
               end else begin
                  w_state_nxt = ACCUM;
               end
            end else begin
               w_state_nxt = ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_acc_nxt   = {ACC_W{1'b0}};
               w_cnt_nxt   = {CNT_W{1'b0}};
               w_ovf_nxt   = 1'b0;
               w_state_nxt = ACCUM;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_acc_nxt   = {ACC_W{1'b0}};
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_ovf_nxt   = 1'b0;
            w_state_nxt = ACCUM;
         end
      endcase
   end

   // State and datapath registers; reset discards any open or pending frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACCUM;
         r_acc   <= {ACC_W{1'b0}};
         r_cnt   <= {CNT_W{1'b0}};
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   // Outputs are the registered frame totals, frozen while holding.
   assign out_sum   = r_acc;
   assign out_count = r_cnt;
   assign out_ovf   = r_ovf;

endmodule : minifloat_accum

// File: tb/tb_minifloat_accum.sv
// tb_minifloat_accum: directed self-checking bench. A 16-bit instance covers
// the general behaviour; a 12-bit instance sharing the same inputs covers
// accumulator overflow.
module tb_minifloat_accum;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_m;
   logic [2:0]  in_e;
   logic        in_last;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_sum;
   logic [5:0]  out_count;
   logic        out_ovf;

   logic        in_ready12;
   logic        out_valid12;
   logic [11:0] out_sum12;
   logic [5:0]  out_count12;
   logic        out_ovf12;

   int checks;
   int errors;

   minifloat_accum #(.ACC_W(16), .CNT_W(6), .FRAME_MAX(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_m      (in_m),
      .in_e      (in_e),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   minifloat_accum #(.ACC_W(12), .CNT_W(6), .FRAME_MAX(32)) dut12 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready12),
      .in_m      (in_m),
      .in_e      (in_e),
      .in_last   (in_last),
      .out_valid (out_valid12),
      .out_ready (out_ready),
      .out_sum   (out_sum12),
      .out_count (out_count12),
      .out_ovf   (out_ovf12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one word for a single edge, then drop in_valid.
   task automatic send(input logic [3:0] m, input logic [2:0] e, input logic last);
      in_valid = 1'b1;
      in_m     = m;
      in_e     = e;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Complete the output handshake in one cycle.
   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'd0 ||
          out_count !== 6'd0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, required 1 0 0 0 0",
                  in_ready, out_valid, out_sum, out_count, out_ovf);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_frame();
      send(4'd5, 3'd0, 1'b0);
      send(4'd8, 3'd1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_early_valid: out_valid=%b, required 0", out_valid);
      end
      send(4'd15, 3'd7, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'd1941 ||
          out_count !== 6'd3 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL frame: vld=%b rdy=%b sum=%0d cnt=%0d ovf=%b, required 1 0 1941 3 0",
                  out_valid, in_ready, out_sum, out_count, out_ovf);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'd0 || out_count !== 6'd0) begin
         errors++;
         $display("FAIL frame_clear: vld=%b rdy=%b sum=%0d cnt=%0d, required 0 1 0 0",
                  out_valid, in_ready, out_sum, out_count);
      end
   endtask

   task automatic test_forced_frame();
      for (int i = 1; i <= 32; i++) begin
         send(4'd1, 3'd0, 1'b0);
         if (i == 31) begin
            checks++;
            if (out_valid !== 1'b0 || out_count !== 6'd31) begin
               errors++;
               $display("FAIL forced_31: vld=%b cnt=%0d, required 0 31", out_valid, out_count);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd32 || out_count !== 6'd32) begin
         errors++;
         $display("FAIL forced_close: vld=%b sum=%0d cnt=%0d, required 1 32 32",
                  out_valid, out_sum, out_count);
      end
      // Word 33 offered while holding must not be taken.
      in_valid = 1'b1;
      in_m     = 4'd2;
      in_e     = 3'd0;
      in_last  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (in_ready !== 1'b0 || out_sum !== 16'd32 || out_count !== 6'd32) begin
         errors++;
         $display("FAIL forced_block33: rdy=%b sum=%0d cnt=%0d, required 0 32 32",
                  in_ready, out_sum, out_count);
      end
      handshake();
      in_valid = 1'b0;
      in_last  = 1'b0;
      send(4'd2, 3'd0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd2 || out_count !== 6'd1) begin
         errors++;
         $display("FAIL forced_word33: vld=%b sum=%0d cnt=%0d, required 1 2 1",
                  out_valid, out_sum, out_count);
      end
      handshake();
   endtask

   task automatic test_overflow();
      logic [11:0] exp_sum12;
`ifdef MINIFLOAT_ACCUM_SAT_EN
      exp_sum12 = 12'd4095;
`else
      exp_sum12 = 12'd1664;
`endif
      send(4'd15, 3'd7, 1'b0);
      send(4'd15, 3'd7, 1'b0);
      send(4'd15, 3'd7, 1'b1);
      checks++;
      if (out_valid12 !== 1'b1 || out_sum12 !== exp_sum12 || out_ovf12 !== 1'b1 ||
          out_count12 !== 6'd3) begin
         errors++;
         $display("FAIL overflow12: vld=%b sum=%0d ovf=%b cnt=%0d, required 1 %0d 1 3",
                  out_valid12, out_sum12, out_ovf12, out_count12, exp_sum12);
      end
      checks++;
      if (out_sum !== 16'd5760 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL overflow16: sum=%0d ovf=%b, required 5760 0", out_sum, out_ovf);
      end
      handshake();
      checks++;
      if (out_ovf12 !== 1'b0 || out_sum12 !== 12'd0) begin
         errors++;
         $display("FAIL overflow_clear: ovf=%b sum=%0d, required 0 0", out_ovf12, out_sum12);
      end
   endtask

   task automatic test_backpressure();
      send(4'd2, 3'd3, 1'b0);
      send(4'd1, 3'd1, 1'b1);
      in_valid = 1'b1;
      in_m     = 4'd9;
      in_e     = 3'd4;
      in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd18 ||
             out_count !== 6'd2 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_c%0d: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, required 0 1 18 2 0",
                     i, in_ready, out_valid, out_sum, out_count, out_ovf);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      handshake();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_bubble: rdy=%b, required 1", in_ready);
      end
      send(4'd4, 3'd0, 1'b1);
      checks++;
      if (out_sum !== 16'd4 || out_count !== 6'd1) begin
         errors++;
         $display("FAIL backpressure_next: sum=%0d cnt=%0d, required 4 1", out_sum, out_count);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      send(4'd3, 3'd2, 1'b0);
      send(4'd3, 3'd2, 1'b0);
      checks++;
      if (out_sum !== 16'd24 || out_count !== 6'd2) begin
         errors++;
         $display("FAIL reset_mid_partial: sum=%0d cnt=%0d, required 24 2", out_sum, out_count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_sum !== 16'd0 || out_count !== 6'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_async: sum=%0d cnt=%0d rdy=%b, required 0 0 1",
                  out_sum, out_count, in_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(4'd1, 3'd0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd1 || out_count !== 6'd1) begin
         errors++;
         $display("FAIL reset_mid_frame: vld=%b sum=%0d cnt=%0d, required 1 1 1",
                  out_valid, out_sum, out_count);
      end
      handshake();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_m      = 4'd0;
      in_e      = 3'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #2;
      test_reset();
      test_frame();
      test_forced_frame();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_minifloat_accum
